// File: rtl/pipeexe_md_if.sv
// EX-stage bundle for pipeexe_md: decoded EX inputs in, stall and EX/MEM register out.
interface pipeexe_md_if #(
    parameter int WIDTH = 32,
    parameter int RW    = 5
);
    logic             ein_valid;
    logic [3:0]       ealuc;
    logic             ealuimm;
    logic             eshift;
    logic             ejal;
    logic [2:0]       emd;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic [WIDTH-1:0] eimm;
    logic [WIDTH-1:0] epc4;
    logic [RW-1:0]    ern0;
    logic             estall;
    logic [WIDTH-1:0] malu;
    logic [RW-1:0]    mrn;
    logic             mvalid;

    modport master (
        output ein_valid, ealuc, ealuimm, eshift, ejal, emd, ea, eb, eimm, epc4, ern0,
        input  estall, malu, mrn, mvalid
    );

    modport slave (
        input  ein_valid, ealuc, ealuimm, eshift, ejal, emd, ea, eb, eimm, epc4, ern0,
        output estall, malu, mrn, mvalid
    );
endinterface

// File: rtl/pipeexe_md.sv
// EX stage with ALU, EX/MEM pipeline register and an iterative unsigned multiply/divide unit.
// state | meaning
// IDLE  | no multiply/divide in flight; done flag marks a just-finished op
// BUSY  | one shift-add / restoring-subtract step per cycle, WIDTH steps
module pipeexe_md #(
    parameter int WIDTH = 32,
    parameter int RW    = 5
) (
    input  logic         clk,
    input  logic         clrn,
    pipeexe_md_if.slave  ex
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic               done_q, done_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               div_q, div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   malu_q, malu_d;
    logic [RW-1:0]      mrn_q, mrn_d;
    logic               mvalid_q, mvalid_d;

    logic               is_mul, is_div, is_md, start, estall;
    logic [WIDTH-1:0]   alua, alub, alu_res, result;
    logic [SW-1:0]      shamt;
    logic [RW-1:0]      dest;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] step_next;

    always_comb begin
        is_mul = (ex.emd == 3'b001);
        is_div = (ex.emd == 3'b010);
        is_md  = is_mul | is_div;
        start  = ex.ein_valid & is_md & ~done_q;
        estall = start | (state_q == BUSY);

        alua  = ex.eshift ? ((ex.eimm >> 6) & WIDTH'(31)) : ex.ea;
        alub  = ex.ealuimm ? ex.eimm : ex.eb;
        shamt = alua[SW-1:0];

        alu_res = '0;
        case (ex.ealuc[2:0])
            3'b000:  alu_res = alua + alub;
            3'b100:  alu_res = alua - alub;
            3'b001:  alu_res = alua & alub;
            3'b101:  alu_res = alua | alub;
            3'b010:  alu_res = alua ^ alub;
            3'b110:  alu_res = alub << 16;
            3'b011:  alu_res = alub << shamt;
            3'b111:  alu_res = ex.ealuc[3] ? WIDTH'($signed(alub) >>> shamt) : (alub >> shamt);
            default: alu_res = '0;
        endcase

        result = alu_res;
        dest   = ex.ern0;
        if (ex.ejal) begin
            result = ex.epc4 + WIDTH'(4);
            dest   = '1;
        end else if (ex.emd == 3'b011) begin
            result = hi_q;
        end else if (ex.emd == 3'b100) begin
            result = lo_q;
        end

        // Multiply keeps {partial product, remaining multiplier}; divide keeps {remainder, quotient}.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opb_q};
        if (!div_q)
            step_next = {mul_sum, acc_q[WIDTH-1:1]};
        else if (div_diff[WIDTH])
            step_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
            step_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        if (estall) begin
            malu_d   = malu_q;
            mrn_d    = '0;
            mvalid_d = 1'b0;
        end else begin
            malu_d   = result;
            mrn_d    = dest;
            mvalid_d = ex.ein_valid & ~is_md;
        end

        state_d = state_q;
        done_d  = estall ? done_q : 1'b0;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    div_d   = is_div;
                    acc_d   = {{WIDTH{1'b0}}, (is_div ? ex.ea : ex.eb)};
                    opb_d   = is_div ? ex.eb : ex.ea;
                end
            end
            BUSY: begin
                acc_d = step_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    hi_d    = step_next[2*WIDTH-1:WIDTH];
                    lo_d    = step_next[WIDTH-1:0];
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            div_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            malu_q   <= '0;
            mrn_q    <= '0;
            mvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            div_q    <= div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            malu_q   <= malu_d;
            mrn_q    <= mrn_d;
            mvalid_q <= mvalid_d;
        end
    end

    assign ex.estall = estall;
    assign ex.malu   = malu_q;
    assign ex.mrn    = mrn_q;
    assign ex.mvalid = mvalid_q;
endmodule

// File: tb/tb_pipeexe_md.sv
// Scoreboard bench for pipeexe_md: directed cases plus random instruction stream vs. an arithmetic model.
module tb_pipeexe_md;
    localparam int W  = 32;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    pipeexe_md_if #(.WIDTH(W), .RW(RW)) ex();
    pipeexe_md #(.WIDTH(W), .RW(RW)) dut (.clk(clk), .clrn(clrn), .ex(ex));

    typedef struct {
        logic        valid;
        logic [3:0]  aluc;
        logic        aluimm;
        logic        shift;
        logic        jal;
        logic [2:0]  md;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rn;
    } instr_t;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  rn;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] ref_alu(input instr_t i);
        logic [31:0] x, y;
        int sh;
        x  = i.shift ? {27'b0, i.imm[10:6]} : i.a;
        y  = i.aluimm ? i.imm : i.b;
        sh = int'(x % 32);
        case (i.aluc)
            4'b0000, 4'b1000: return y + x;
            4'b0100, 4'b1100: return x + (~y + 32'd1);
            4'b0001, 4'b1001: return x & y;
            4'b0101, 4'b1101: return x | y;
            4'b0010, 4'b1010: return x ^ y;
            4'b0110, 4'b1110: return y * 32'h10000;
            4'b0011, 4'b1011: return y * (32'd1 << sh);
            4'b0111:          return y / (32'd1 << sh);
            4'b1111:          return (y / (32'd1 << sh)) | (y[31] ? ~(32'hFFFF_FFFF / (32'd1 << sh)) : 32'd0);
            default:          return 32'd0;
        endcase
    endfunction

    function automatic instr_t nop();
        instr_t i;
        i.valid = 1'b0; i.aluc = 4'd0; i.aluimm = 1'b0; i.shift = 1'b0; i.jal = 1'b0;
        i.md = 3'd0; i.a = '0; i.b = '0; i.imm = '0; i.pc4 = '0; i.rn = '0;
        return i;
    endfunction

    function automatic instr_t mk(input logic [2:0] md, input logic [3:0] aluc,
                                  input logic [31:0] a, input logic [31:0] b, input logic [4:0] rn);
        instr_t i;
        i = nop();
        i.valid = 1'b1; i.md = md; i.aluc = aluc; i.a = a; i.b = b; i.rn = rn;
        return i;
    endfunction

    task automatic drive(input instr_t i);
        ex.ein_valid = i.valid;
        ex.ealuc     = i.aluc;
        ex.ealuimm   = i.aluimm;
        ex.eshift    = i.shift;
        ex.ejal      = i.jal;
        ex.emd       = i.md;
        ex.ea        = i.a;
        ex.eb        = i.b;
        ex.eimm      = i.imm;
        ex.epc4      = i.pc4;
        ex.ern0      = i.rn;
    endtask

    // Hold the instruction until the edge that accepts it; expected result is queued at acceptance.
    task automatic issue(input instr_t i, input string nm);
        int   stalls;
        logic ok;
        logic [63:0] p;
        exp_t e;
        drive(i);
        stalls = 0;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!ex.estall) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: estall still high after %0d cycles, required low", nm, stalls);
        end
        if (i.valid && (i.md == 3'b001 || i.md == 3'b010)) begin
            check({nm, "_stall_cycles"}, stalls, W + 1);
            if (i.md == 3'b001) begin
                p = {32'b0, i.a} * {32'b0, i.b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end else if (i.b == 0) begin
                m_hi = i.a;
                m_lo = 32'hFFFF_FFFF;
            end else begin
                m_hi = i.a % i.b;
                m_lo = i.a / i.b;
            end
        end else begin
            check({nm, "_stall_cycles"}, stalls, 0);
            if (i.valid) begin
                e.name = nm;
                e.rn   = i.rn;
                if (i.jal) begin
                    e.alu = i.pc4 + 32'd4;
                    e.rn  = 5'd31;
                end else if (i.md == 3'b011) e.alu = m_hi;
                else if (i.md == 3'b100)     e.alu = m_lo;
                else                         e.alu = ref_alu(i);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        int sel;
        i = nop();
        i.valid  = ($urandom_range(0, 9) != 0);
        i.a      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
        i.b      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
        i.imm    = {{16{1'b0}}, 16'($urandom)};
        i.imm    = {{16{i.imm[15]}}, i.imm[15:0]};
        i.pc4    = $urandom;
        i.rn     = 5'($urandom);
        sel = $urandom_range(0, 9);
        if (sel <= 4) begin
            i.aluc   = 4'($urandom);
            if (i.aluc == 4'b1011) i.aluc = 4'b0011;
            i.aluimm = 1'($urandom);
            i.shift  = 1'($urandom);
            case ($urandom_range(0, 3))
                0: i.md = 3'b000;
                1: i.md = 3'b101;
                2: i.md = 3'b110;
                default: i.md = 3'b111;
            endcase
        end else if (sel == 5) i.jal = 1'b1;
        else if (sel == 6) i.md = 3'b001;
        else if (sel == 7) begin
            i.md = 3'b010;
            if ($urandom_range(0, 4) == 0) i.b = '0;
        end
        else if (sel == 8) i.md = 3'b011;
        else i.md = 3'b100;
        return i;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (clrn === 1'b1 && ex.mvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_mvalid: malu %h mrn %0d with nothing outstanding", ex.malu, ex.mrn);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_malu"}, ex.malu, e.alu);
                    check({e.name, "_mrn"}, ex.mrn, e.rn);
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin : stim
        instr_t i;
        clrn = 1'b0;
        drive(mk(3'b001, 4'd0, 32'd3, 32'd4, 5'd0));
        #1;
        check("reset_estall_follows_request", ex.estall, 1'b1);
        check("reset_malu", ex.malu, 0);
        check("reset_mrn", ex.mrn, 0);
        check("reset_mvalid", ex.mvalid, 0);
        drive(nop());
        #1;
        check("reset_estall_idle", ex.estall, 1'b0);
        #20;
        clrn = 1'b1;
        @(posedge clk);
        #1;

        issue(mk(3'b000, 4'b0000, 32'd5, 32'd7, 5'd3), "add");
        i = nop(); i.valid = 1'b1; i.jal = 1'b1; i.pc4 = 32'h0040_0004;
        issue(i, "jal");
        i = mk(3'b000, 4'b1111, 32'd0, 32'h8000_0000, 5'd9); i.shift = 1'b1; i.imm = 32'h0000_0100;
        issue(i, "sra");
        issue(mk(3'b001, 4'd0, 32'hFFFF_FFFF, 32'd2, 5'd0), "multu_max");
        issue(mk(3'b011, 4'd0, 32'd0, 32'd0, 5'd4), "mfhi_after_multu");
        issue(mk(3'b100, 4'd0, 32'd0, 32'd0, 5'd5), "mflo_after_multu");
        issue(mk(3'b010, 4'd0, 32'd100, 32'd7, 5'd0), "divu_100_7");
        issue(mk(3'b100, 4'd0, 32'd0, 32'd0, 5'd6), "mflo_after_divu");
        issue(mk(3'b011, 4'd0, 32'd0, 32'd0, 5'd7), "mfhi_after_divu");
        issue(mk(3'b010, 4'd0, 32'd9, 32'd0, 5'd0), "divu_by_zero");
        issue(mk(3'b100, 4'd0, 32'd0, 32'd0, 5'd8), "mflo_div0");
        issue(mk(3'b011, 4'd0, 32'd0, 32'd0, 5'd10), "mfhi_div0");
        issue(mk(3'b010, 4'd0, 32'd7, 32'd9, 5'd0), "divu_small");
        issue(mk(3'b001, 4'd0, 32'd6, 32'd7, 5'd0), "multu_back_to_back");
        issue(mk(3'b100, 4'd0, 32'd0, 32'd0, 5'd11), "mflo_b2b");

        for (int n = 0; n < 150; n++) issue(rand_instr(), "rand");

        drive(nop());
        repeat (3) @(negedge clk);
        check("queue_drained_before_abort", exp_q.size(), 0);

        // Abort a multiply mid-flight: 1 accept-stall cycle plus 10 BUSY steps, then async clear.
        drive(mk(3'b001, 4'd0, 32'd5, 32'd6, 5'd0));
        repeat (11) @(negedge clk);
        check("abort_busy_before_reset", ex.estall, 1'b1);
        #2;
        ex.ein_valid = 1'b0;
        clrn = 1'b0;
        #1;
        check("abort_estall", ex.estall, 1'b0);
        check("abort_mvalid", ex.mvalid, 1'b0);
        check("abort_malu", ex.malu, 0);
        m_hi = '0;
        m_lo = '0;
        @(posedge clk);
        #3;
        clrn = 1'b1;
        @(posedge clk);
        #1;
        issue(mk(3'b011, 4'd0, 32'd0, 32'd0, 5'd12), "mfhi_after_abort");
        issue(mk(3'b100, 4'd0, 32'd0, 32'd0, 5'd13), "mflo_after_abort");
        issue(mk(3'b001, 4'd0, 32'd3, 32'd4, 5'd0), "multu_3_4");
        issue(mk(3'b100, 4'd0, 32'd0, 32'd0, 5'd14), "mflo_3_4");
        issue(mk(3'b011, 4'd0, 32'd0, 32'd0, 5'd15), "mfhi_3_4");

        drive(nop());
        repeat (3) @(negedge clk);
        check("queue_drained_final", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeexe_md.md
PIPEEXE_MD -- requirements
Module: pipeexe_md

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width (even, >=8).
REQ-002 The block SHALL have parameter RW, default 5, destination-register index width.
REQ-003 The block SHALL have a single clock and an asynchronous active-low reset; clock clk, reset clrn.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 clrn  in  1  async active-low clear.
REQ-006 ein_valid  in  1  EX holds a valid instruction.
REQ-007 ealuc  in  4  ALU op code.
REQ-008 ealuimm, eshift, ejal  in  1 each  select imm as B; select shamt as A; jal.
REQ-009 emd  in  3  000 none, 001 multu, 010 divu, 011 mfhi, 100 mflo; others treated as 000.
REQ-010 ea, eb, eimm, epc4  in  WIDTH each  operand A, operand B, sign-extended imm, PC+4.
REQ-011 ern0  in  RW  decoded destination register.
REQ-012 estall  out  1  combinational; freezes upstream stages and EX inputs.
REQ-013 malu  out  WIDTH  registered EX/MEM result.
REQ-014 mrn  out  RW  registered EX/MEM destination.
REQ-015 mvalid  out  1  registered EX/MEM valid.

Function
REQ-016 alua SHALL be ea, or zero-extended eimm[10:6] when eshift=1; alub SHALL be eb, or eimm when ealuimm=1.
REQ-017 ALU ops (ealuc) SHALL be: x000 add, x100 sub, x001 and, x101 or, x010 xor, x110 lui ({alub[15:0],0}), 0011 sll, 0111 srl, 1111 sra; shifts move alub by alua[$clog2(WIDTH)-1:0]; add/sub wrap modulo 2^WIDTH.
REQ-018 ejal=1 SHALL force result = epc4+4 (mod 2^WIDTH) and destination = all ones.
REQ-019 emd=011/100 SHALL force result = HI/LO, destination = ern0, single cycle.
REQ-020 When estall=0, each edge SHALL load malu<=result, mrn<=destination, mvalid<=ein_valid & (emd not multu/divu).
REQ-021 When estall=1, each edge SHALL load mvalid<=0, mrn<=0, with malu held (bubble).
REQ-022 FSM states SHALL be IDLE and BUSY, plus a 1-bit done flag and a $clog2(WIDTH)+1-bit step counter.
REQ-023 estall SHALL equal ein_valid & (emd==multu|divu) & ~done, OR state==BUSY.
REQ-024 IDLE->BUSY on edge with ein_valid, emd multu/divu, done=0: operands latched, counter=0.
REQ-025 BUSY SHALL perform one shift-add (multu) or restoring-subtract (divu) step per cycle, unsigned, for exactly WIDTH cycles.
REQ-026 On the WIDTH-th BUSY edge: multu writes {HI,LO}=full 2*WIDTH product; divu writes LO=quotient, HI=remainder; state->IDLE, done<=1.
REQ-027 done SHALL clear on the first edge with estall=0; total stall per multu/divu = WIDTH+1 cycles.
REQ-028 divu by zero SHALL yield LO=all ones, HI=dividend, same latency.
REQ-029 mfhi/mflo in the cycle after done is set SHALL return the newly written HI/LO.
REQ-030 HI/LO SHALL change only per REQ-026 or reset.

Reset
REQ-031 clrn=0 SHALL immediately force state=IDLE, counter=0, done=0, HI=LO=0, malu=0, mrn=0, mvalid=0, independent of clk.
REQ-032 Reset asserted during BUSY SHALL abort the operation with HI/LO=0; no partial result is committed after release.
REQ-033 While clrn=0, estall SHALL follow REQ-023 with state=IDLE, done=0.

Verification
REQ-034 add: ea=5, eb=7, ealuc=0000, ein_valid=1, ern0=3 -> next edge malu=12, mrn=3, mvalid=1.
REQ-035 jal: ejal=1, epc4=0x00400004 -> malu=0x00400008, mrn=31, mvalid=1.
REQ-036 sra: eshift=1, eimm[10:6]=4, eb=0x80000000, ealuc=1111 -> malu=0xF8000000.
REQ-037 multu 0xFFFFFFFF*2 -> estall high 33 cycles, mvalid 0 throughout; HI=1, LO=0xFFFFFFFE; following mfhi -> malu=1.
REQ-038 divu 100/7 -> LO=14, HI=2 after 33 stall cycles; divu 9/0 -> LO=0xFFFFFFFF, HI=9.
REQ-039 clrn low at BUSY step 10 with ein_valid dropped -> estall=0 at once, HI=LO=0, mvalid=0; fresh multu 3*4 after release -> LO=12, HI=0.
